// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state encoding and default parameters for the MLP stream engine
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FRAC_WIDTH = 5;
  localparam int DEF_N          = 4;
  localparam int DEF_M          = 3;
  localparam int DEF_RELU_EN    = 0;

endpackage

// File: rtl/mlp_neuron_sat.sv
// rtl/mlp_neuron_sat.sv - one fixed-point neuron: dot product, bias, rescale, saturate, optional ReLU
module mlp_neuron_sat
  import mlp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int N          = DEF_N,
  parameter int RELU_EN    = DEF_RELU_EN
) (
  input  logic signed [WIDTH-1:0] vec   [N],
  input  logic signed [WIDTH-1:0] w_row [N],
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] res
);

  // Wide enough that N full-precision products plus the aligned bias never overflow
  localparam int AW = 2*WIDTH + $clog2(N+1);
  localparam logic signed [AW-1:0] MAX_V = AW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = -MAX_V - AW'(1);

  logic signed [2*WIDTH-1:0] prod [N];
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      shifted;
  logic signed [WIDTH-1:0]   sat;

  // Accumulate products, rescale by arithmetic shift (floor), clamp, then rectify if enabled
  always_comb begin
    acc = AW'(bias) <<< FRAC_WIDTH;
    for (int j = 0; j < N; j++) begin
      prod[j] = vec[j] * w_row[j];
      acc     = acc + AW'(prod[j]);
    end
    shifted = acc >>> FRAC_WIDTH;
    if (shifted > MAX_V) begin
      sat = MAX_V[WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[WIDTH-1:0];
    end else begin
      sat = shifted[WIDTH-1:0];
    end
    res = sat;
    if (RELU_EN != 0 && sat[WIDTH-1]) begin
      res = '0;
    end
  end

endmodule

// File: rtl/mlp_stream.sv
// rtl/mlp_stream.sv - multi-layer perceptron engine, one layer per clock, valid/ready in and out
module mlp_stream
  import mlp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int N          = DEF_N,
  parameter int M          = DEF_M,
  parameter int RELU_EN    = DEF_RELU_EN,
  localparam int LW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data   [N],
  output logic [LW-1:0]           layer_idx,
  input  logic signed [WIDTH-1:0] weights   [N][N],
  input  logic signed [WIDTH-1:0] bias      [N],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data  [N],
  output logic                    busy
);

  localparam logic [LW-1:0] LAST_LAYER = LW'(M-1);

  state_t                  state;
  logic [LW-1:0]           layer;
  logic                    idle_q;
  logic signed [WIDTH-1:0] vec [N];
  logic signed [WIDTH-1:0] nxt [N];

  // All neurons of the current layer evaluate in parallel from the vector register
  for (genvar i = 0; i < N; i++) begin : g_neuron
    mlp_neuron_sat #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .N          (N),
      .RELU_EN    (RELU_EN)
    ) u_neuron (
      .vec   (vec),
      .w_row (weights[i]),
      .bias  (bias[i]),
      .res   (nxt[i])
    );
  end

  // The layer counter is zero whenever the engine is not computing, so it doubles as layer_idx
  assign layer_idx = layer;
  assign out_data  = vec;
  // In DONE a new vector can enter in the same cycle the result leaves
  assign in_ready  = idle_q | (out_valid & out_ready);

  // Control FSM with registered status flags; vector register and layer counter live here too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      layer     <= '0;
      idle_q    <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < N; i++) vec[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec    <= in_data;
            layer  <= '0;
            state  <= COMPUTE;
            idle_q <= 1'b0;
            busy   <= 1'b1;
          end
        end
        COMPUTE: begin
          vec <= nxt;
          if (layer == LAST_LAYER) begin
            layer     <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            layer <= layer + LW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              vec   <= in_data;
              layer <= '0;
              state <= COMPUTE;
              busy  <= 1'b1;
            end else begin
              state  <= IDLE;
              idle_q <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          layer     <= '0;
          idle_q    <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_stream.sv
// tb/tb_mlp_stream.sv - directed vector bench for mlp_stream, linear and ReLU instances in lockstep
module tb_mlp_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] in_data [4];

  logic in_ready_l, out_valid_l, busy_l;
  logic in_ready_r, out_valid_r, busy_r;
  logic [1:0] idx_l, idx_r;
  logic signed [7:0] weights_l [4][4];
  logic signed [7:0] weights_r [4][4];
  logic signed [7:0] bias_l [4];
  logic signed [7:0] bias_r [4];
  logic signed [7:0] out_l [4];
  logic signed [7:0] out_r [4];

  logic signed [7:0] w_cfg [3][4][4];
  logic signed [7:0] b_cfg [3][4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mlp_stream #(.WIDTH(8), .FRAC_WIDTH(5), .N(4), .M(3), .RELU_EN(0)) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .layer_idx(idx_l), .weights(weights_l), .bias(bias_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_data(out_l), .busy(busy_l)
  );

  mlp_stream #(.WIDTH(8), .FRAC_WIDTH(5), .N(4), .M(3), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .layer_idx(idx_r), .weights(weights_r), .bias(bias_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_r), .busy(busy_r)
  );

  // Combinational weight store indexed by each instance's layer_idx
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bias_l[i] = (idx_l < 2'd3) ? b_cfg[idx_l][i] : 8'sd0;
      bias_r[i] = (idx_r < 2'd3) ? b_cfg[idx_r][i] : 8'sd0;
      for (int j = 0; j < 4; j++) begin
        weights_l[i][j] = (idx_l < 2'd3) ? w_cfg[idx_l][i][j] : 8'sd0;
        weights_r[i][j] = (idx_r < 2'd3) ? w_cfg[idx_r][i][j] : 8'sd0;
      end
    end
  end

  typedef struct {
    int wd;
    int wo;
    int rot;
    int b[4];
    int lb;
    int x[4];
    int el[4];
    int er[4];
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int k);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) begin
        b_cfg[l][i] = 8'(vt[k].b[i] + vt[k].lb * l);
        for (int j = 0; j < 4; j++) begin
          if ((vt[k].rot != 0) ? (j == (i + 1) % 4) : (j == i))
            w_cfg[l][i][j] = 8'(vt[k].wd);
          else
            w_cfg[l][i][j] = 8'(vt[k].wo);
        end
      end
    end
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    in_data[0] = 8'(a); in_data[1] = 8'(b); in_data[2] = 8'(c); in_data[3] = 8'(d);
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " drain out_valid"}, int'(out_valid_l), 0);
    chk({nm, " drain in_ready"}, int'(in_ready_l), 1);
  endtask

  task automatic run_vec(input int k);
    string nm;
    nm = $sformatf("vec%0d", k);
    @(negedge clk);
    set_cfg(k);
    set_x(vt[k].x[0], vt[k].x[1], vt[k].x[2], vt[k].x[3]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk({nm, " in_ready"}, int'(in_ready_l & in_ready_r), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("%s layer_idx%0d", nm, l), int'(idx_l), l);
      chk($sformatf("%s busy%0d", nm, l), int'(busy_l), 1);
      chk($sformatf("%s early out_valid%0d", nm, l), int'(out_valid_l), 0);
      @(posedge clk); #1;
    end
    chk({nm, " out_valid"}, int'(out_valid_l & out_valid_r), 1);
    chk({nm, " layer_idx done"}, int'(idx_l), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s lin[%0d]", nm, i), int'(out_l[i]), vt[k].el[i]);
      chk($sformatf("%s relu[%0d]", nm, i), int'(out_r[i]), vt[k].er[i]);
    end
    drain(nm);
  endtask

  initial begin
    vt[0] = '{32, 0, 0, '{0,0,0,0}, 0, '{10,-20,30,-40}, '{10,-20,30,-40}, '{10,0,30,0}};
    vt[1] = '{127, 127, 0, '{0,0,0,0}, 0, '{127,127,127,127}, '{127,127,127,127}, '{127,127,127,127}};
    vt[2] = '{127, 127, 0, '{0,0,0,0}, 0, '{-128,-128,-128,-128}, '{-128,-128,-128,-128}, '{0,0,0,0}};
    vt[3] = '{32, 0, 0, '{16,0,0,0}, 0, '{0,0,0,0}, '{48,0,0,0}, '{48,0,0,0}};
    vt[4] = '{16, 0, 0, '{0,0,0,0}, 0, '{1,-1,3,-3}, '{0,-1,0,-1}, '{0,0,0,0}};
    vt[5] = '{32, 0, 0, '{0,0,0,0}, 0, '{-10,5,-1,0}, '{-10,5,-1,0}, '{0,5,0,0}};
    vt[6] = '{32, 0, 0, '{1,1,1,1}, 1, '{0,0,0,0}, '{6,6,6,6}, '{6,6,6,6}};
    vt[7] = '{32, 0, 1, '{0,0,0,0}, 0, '{1,2,3,4}, '{4,1,2,3}, '{4,1,2,3}};
    vt[8] = '{0, 32, 0, '{0,0,0,0}, 0, '{1,2,3,4}, '{69,68,67,66}, '{69,68,67,66}};

    set_cfg(0);
    set_x(0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", int'(out_valid_l | out_valid_r), 0);
    chk("rst in_ready", int'(in_ready_l & in_ready_r), 1);
    chk("rst busy", int'(busy_l | busy_r), 0);
    chk("rst layer_idx", int'(idx_l), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst out[%0d]", i), int'(out_l[i]), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run_vec(k);

    // backpressure, in_valid ignored while computing, back-to-back accept from DONE
    @(negedge clk);
    set_cfg(0);
    set_x(10, -20, 30, -40);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_x(99, 99, 99, 99);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp out_valid c%0d", c), int'(out_valid_l), 1);
      chk($sformatf("bp in_ready c%0d", c), int'(in_ready_l), 0);
      chk($sformatf("bp out0 c%0d", c), int'(out_l[0]), 10);
      chk($sformatf("bp out1 c%0d", c), int'(out_l[1]), -20);
      chk($sformatf("bp out3 c%0d", c), int'(out_l[3]), -40);
      @(posedge clk); #1;
    end
    @(negedge clk);
    set_x(1, 2, 3, 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", int'(in_ready_l), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b busy", int'(busy_l), 1);
    chk("b2b out_valid e1", int'(out_valid_l), 0);
    @(posedge clk); #1;
    chk("b2b out_valid e2", int'(out_valid_l), 0);
    @(posedge clk); #1;
    chk("b2b out_valid e3", int'(out_valid_l), 0);
    @(posedge clk); #1;
    chk("b2b out_valid e4", int'(out_valid_l), 1);
    chk("b2b out0", int'(out_l[0]), 1);
    chk("b2b out2", int'(out_l[2]), 3);
    chk("b2b out3", int'(out_l[3]), 4);
    drain("b2b");

    // asynchronous reset during layer 1, then immediate accept
    @(negedge clk);
    set_x(5, 6, 7, 8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid layer_idx", int'(idx_l), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", int'(out_valid_l), 0);
    chk("mid rst in_ready", int'(in_ready_l), 1);
    chk("mid rst layer_idx", int'(idx_l), 0);
    chk("mid rst busy", int'(busy_l), 0);
    chk("mid rst out0", int'(out_l[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    set_x(-3, -2, -1, 7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post rst busy", int'(busy_l & busy_r), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post rst out_valid", int'(out_valid_l & out_valid_r), 1);
    chk("post rst lin0", int'(out_l[0]), -3);
    chk("post rst lin3", int'(out_l[3]), 7);
    chk("post rst relu0", int'(out_r[0]), 0);
    chk("post rst relu3", int'(out_r[3]), 7);
    drain("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mlp_stream.md
Name: mlp_stream

Overview:
- Multi-layer perceptron engine with handshakes. Each layer is N fixed-point neurons wide; the engine runs M layers on one input vector.
- One layer is evaluated per clock. All N neurons of the layer are computed in parallel and the result is fed back into a vector register for the next layer.
- Weights and biases come from an external, combinationally indexed store selected by the `layer_idx` output.
- Adds valid/ready streaming, saturation, an optional ReLU and a configurable Q-format.

Parameters:
- WIDTH, 8, total data/weight/bias width in bits (signed two's complement).
- FRAC_WIDTH, 5, fractional bits of the Q format. Range 0..WIDTH-1.
- N, 4, neurons per layer, which is also the vector length.
- M, 3, number of layers. Must be ≥1.
- RELU_EN, 0, 1 applies ReLU after saturation in every layer; 0 means linear output.
- LW, max(1,$clog2(M)), width of the layer index (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept an input vector
- in_data  in  signed [WIDTH-1:0] x N  input vector
- layer_idx  out  LW  layer whose weights/bias must be presented this cycle
- weights  in  signed [WIDTH-1:0] x N x N  weights[i][j] = weight from input j to neuron i, for layer_idx
- bias  in  signed [WIDTH-1:0] x N  per-neuron bias, for layer_idx
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts the result
- out_data  out  signed [WIDTH-1:0] x N  result vector, identical to the vector register
- busy  out  1  high in COMPUTE

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, vector register = 0, layer counter = 0.
  - out_valid=0, in_ready=1, busy=0, layer_idx=0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load in_data into the vector register, set layer=0, go to COMPUTE.
- COMPUTE:
  - layer_idx=layer.
  - Each clock: vector register ← neuron outputs, layer←layer+1.
  - When layer==M-1, the update takes place, layer is cleared to 0 and the state goes to DONE.
  - in_ready=0. in_valid is ignored.
- DONE:
  - out_valid=1. out_data is held stable until out_ready.
  - On out_ready:
    - if in_valid is also high, load the new input and go to COMPUTE (back-to-back; in_ready=out_ready in DONE);
    - otherwise go to IDLE.
- Latency: handshake at edge k → out_valid rises after edge k+M, so the first DONE cycle is k+M. Throughput is one vector per M+1 cycles.
- layer_idx is 0 outside COMPUTE. The weight store is combinational; no read latency is allowed.
- Neuron arithmetic:
  - Accumulator width AW = 2*WIDTH + $clog2(N+1).
  - acc = Σ_j vec[j]*weights[i][j] + (bias[i] <<< FRAC_WIDTH), with full-precision signed products and no intermediate overflow.
  - res = acc >>> FRAC_WIDTH, an arithmetic shift that truncates toward −∞.
  - Saturate res to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - If RELU_EN, negative values → 0.
- Reset mid-operation: the state and any in-flight vector are discarded immediately. The first accept is possible in the first cycle after rst deasserts.
- in_data is not sampled unless the handshake completes. A dropped in_valid before acceptance is legal.

Decomposition:
- Package mlp_pkg:
  - state enum (IDLE/COMPUTE/DONE);
  - sat() function template constants (max/min per WIDTH computed in-module);
  - default parameter values.
- Sub-module mlp_neuron_sat #(WIDTH, FRAC_WIDTH, N, RELU_EN):
  - combinational; inputs vec[N], w_row[N], bias; output one saturated neuron value;
  - instantiated N times in a generate loop.
- The top holds the FSM, layer counter and vector register.

Test Plan (WIDTH=8, FRAC=5, N=4, M=3; 1.0=32):
- Identity weights (diag 32, else 0), bias 0, RELU_EN=0, in_data=[10,−20,30,−40] accepted at cycle 0:
  - layer_idx sequence is 0,1,2;
  - out_valid rises at cycle 3;
  - out_data=[10,−20,30,−40].
- All weights 127, bias 0, in_data all 127:
  - layer 0 acc=64516 → 2016 → saturates to 127; final out all 127.
  - With in_data all −128: out all −128.
- Diag 32, bias=[16,0,0,0], in_data=[0,0,0,0], M=3 → out_data[0]=48 (16 added per layer), others 0.
- RELU_EN=1, identity weights, in_data=[−10,5,−1,0] → out_data=[0,5,0,0].
- Backpressure: out_ready low for 5 cycles in DONE:
  - out_data stable, out_valid stays 1, in_ready 0;
  - then out_ready=1 with in_valid=1 → new vector accepted in the same cycle, next out_valid 3 cycles later.
- Assert rst during COMPUTE (layer 1):
  - out_valid=0, in_ready=1, layer_idx=0 immediately;
  - a new vector is accepted in the first post-reset cycle and completes correctly.
